operand_fetch_stage: RTL



---
 rtl/operand_fetch_stage.sv | 115 +++++++++++
 1 files changed

// File: rtl/operand_fetch_stage.sv
// Operand-fetch stage: decodes the instruction, reads R[rs1]/R[rs2] with a busy scoreboard
// for RAW hazards, and registers A/B/D/out_rd for execute. Define OF_WB_BYPASS_EN for writeback bypass.
module operand_fetch_stage #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic            wb_en,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] A,
    output logic [XLEN-1:0] B,
    output logic [2:0]      D,
    output logic [4:0]      out_rd
);

    function automatic logic signed [XLEN-1:0] sext_imm(input logic signed [12:0] imm);
        return {{(XLEN-13){imm[12]}}, imm};
    endfunction

    logic [2:0]         op_p0;
    logic [4:0]         rd_p0;
    logic [4:0]         rs1_p0;
    logic [4:0]         rs2_p0;
    logic               use_imm_p0;
    logic signed [12:0] imm_p0;

    assign {op_p0, rd_p0, rs1_p0, rs2_p0, use_imm_p0, imm_p0} = in_instr;

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] wb_clr;
    logic [NREG-1:0] issue_set;
    logic [NREG-1:0] busy_eff;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic            hazard;
    logic            issue;

    logic            vld_p1;
    logic [XLEN-1:0] a_p1;
    logic signed [XLEN-1:0] b_p1;
    logic [2:0]      d_p1;
    logic [4:0]      rd_p1;

    always_comb begin
        wb_clr = '0;
        if (wb_en) wb_clr[wb_addr] = 1'b1;
        issue_set = '0;
        if (issue && rd_p0 != '0) issue_set[rd_p0] = 1'b1;
    end

    always_comb begin
        rs1_val = (rs1_p0 == '0) ? '0 : regs[rs1_p0];
        rs2_val = (rs2_p0 == '0) ? '0 : regs[rs2_p0];
`ifdef OF_WB_BYPASS_EN
        if (wb_en && wb_addr != '0 && wb_addr == rs1_p0) rs1_val = wb_data;
        if (wb_en && wb_addr != '0 && wb_addr == rs2_p0) rs2_val = wb_data;
        busy_eff = busy & ~wb_clr;
`else
        busy_eff = busy;
`endif
        hazard = (rs1_p0 != '0 && busy_eff[rs1_p0]) ||
                 (!use_imm_p0 && rs2_p0 != '0 && busy_eff[rs2_p0]);
    end

    assign in_ready = (!vld_p1 || out_ready) && !hazard;
    assign issue    = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wb_en && wb_addr != '0) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // Set has priority over a same-cycle writeback clear of the same index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy <= '0;
        else        busy <= (busy & ~wb_clr) | issue_set;
    end

    // ---- p0 -> p1: operand register toward execute ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            a_p1   <= '0;
            b_p1   <= '0;
            d_p1   <= '0;
            rd_p1  <= '0;
        end else if (issue) begin
            vld_p1 <= 1'b1;
            a_p1   <= rs1_val;
            b_p1   <= use_imm_p0 ? sext_imm(imm_p0) : $signed(rs2_val);
            d_p1   <= op_p0;
            rd_p1  <= rd_p0;
        end else if (out_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    assign out_valid = vld_p1;
    assign A         = a_p1;
    assign B         = b_p1;
    assign D         = d_p1;
    assign out_rd    = rd_p1;

endmodule
